// File: rtl/mem_image_loader.sv
// mem_image_loader: streams an image into memory, verifies it by read-back checksum, then releases the CPU reset
module mem_image_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_WIDTH  = 2**(ADDR_WIDTH-2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] word_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic [ADDR_WIDTH-1:0] mem_Waddr,
    output logic                  mem_Wren,
    output logic [31:0]           mem_Wdata,
    output logic [ADDR_WIDTH-1:0] mem_Raddr,
    output logic                  mem_Rden,
    input  logic [31:0]           mem_Rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum,
    output logic                  cpu_rst
);
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, ERR} state_t;
    localparam logic [ADDR_WIDTH-2:0] CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-3:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH-2:0] MAX_CNT = MEM_WIDTH[ADDR_WIDTH-2:0];
    state_t                state;
    logic [ADDR_WIDTH-3:0] ptr;
    logic [ADDR_WIDTH-2:0] cnt;
    logic [31:0]           load_sum, rd_sum, rd_sum_next;
    logic                  last;
    always_comb begin
        last        = {1'b0, ptr} == cnt - CNT_ONE;
        rd_sum_next = rd_sum + mem_Rdata;
        in_ready    = state == LOAD;
        mem_Wren    = in_ready && in_valid;
        mem_Waddr   = in_ready ? {2'b00, ptr} : '0;
        mem_Wdata   = in_ready ? in_data : '0;
        mem_Rden    = state == VERIFY;
        mem_Raddr   = mem_Rden ? {2'b00, ptr} : '0;
        busy        = in_ready || mem_Rden;
        done        = state == DONE;
        error       = state == ERR;
        cpu_rst     = !done;
        checksum    = done ? load_sum : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            load_sum <= '0;
            rd_sum   <= '0;
        end else begin
            case (state)
                IDLE, ERR: if (start) begin
                    ptr      <= '0;
                    cnt      <= word_count;
                    load_sum <= '0;
                    rd_sum   <= '0;
                    state    <= word_count > MAX_CNT ? ERR : word_count == '0 ? DONE : LOAD;
                end
                LOAD: if (in_valid) begin
                    load_sum <= load_sum + in_data;
                    ptr      <= last ? '0 : ptr + PTR_ONE;
                    if (last) state <= VERIFY;
                end
                VERIFY: begin
                    rd_sum <= rd_sum_next;
                    ptr    <= ptr + PTR_ONE;
                    if (last) state <= rd_sum_next == load_sum ? DONE : ERR;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: directed vectors checked against a phase-level model of the image loader
module tb_mem_image_loader;
    localparam int AW = 10;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, corrupt = 0, armed = 0;
    logic in_ready, mem_Wren, mem_Rden, busy, done, error, cpu_rst;
    logic [AW-2:0] word_count = '0;
    logic [31:0] in_data = '0, mem_Wdata, mem_Rdata, checksum;
    logic [AW-1:0] mem_Waddr, mem_Raddr;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] img [0:255];
    logic [31:0] words [0:3] = '{32'h241a0001, 32'h17400002, 32'h00000000, 32'hffffffff};
    int vectors = 0, fails = 0, wr_cnt = 0, rd_cnt = 0, last_waddr = -1;
    int m_phase = 0, m_cnt = 0, m_ptr = 0;
    logic [31:0] m_sum = '0;

    always #5 clk = ~clk;

    mem_image_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_Waddr(mem_Waddr), .mem_Wren(mem_Wren), .mem_Wdata(mem_Wdata),
        .mem_Raddr(mem_Raddr), .mem_Rden(mem_Rden), .mem_Rdata(mem_Rdata),
        .busy(busy), .done(done), .error(error), .checksum(checksum), .cpu_rst(cpu_rst)
    );

    always @(posedge clk) if (mem_Wren) mem[mem_Waddr] <= mem_Wdata;
    assign mem_Rdata = mem[mem_Raddr] ^ {31'b0, corrupt && mem_Raddr == 2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // phases: 0 idle, 1 load, 2 verify, 3 done, 4 error
    always @(negedge clk) if (armed) begin
        check("in_ready", in_ready, m_phase == 1);
        check("mem_Wren", mem_Wren, m_phase == 1 && in_valid);
        check("mem_Waddr", mem_Waddr, m_phase == 1 ? m_ptr : 0);
        check("mem_Wdata", mem_Wdata, m_phase == 1 ? in_data : 0);
        check("mem_Rden", mem_Rden, m_phase == 2);
        check("mem_Raddr", mem_Raddr, m_phase == 2 ? m_ptr : 0);
        check("busy", busy, m_phase == 1 || m_phase == 2);
        check("done", done, m_phase == 3);
        check("error", error, m_phase == 4);
        check("cpu_rst", cpu_rst, m_phase != 3);
        check("checksum", checksum, m_phase == 3 ? m_sum : 0);
        wr_cnt += mem_Wren;
        rd_cnt += mem_Rden;
        if (mem_Wren) last_waddr = mem_Waddr;
        if (rst) m_phase = 0;
        else if ((m_phase == 0 || m_phase == 4) && start) begin
            if (word_count > 256) m_phase = 4;
            else if (word_count == 0) begin m_phase = 3; m_sum = 0; end
            else begin m_phase = 1; m_cnt = word_count; m_ptr = 0; end
        end else if (m_phase == 1 && in_valid) begin
            img[m_ptr] = in_data;
            m_ptr++;
            if (m_ptr == m_cnt) begin m_phase = 2; m_ptr = 0; end
        end else if (m_phase == 2) begin
            m_ptr++;
            if (m_ptr == m_cnt) begin
                m_sum = 0;
                for (int i = 0; i < m_cnt; i++) m_sum += img[i];
                m_phase = corrupt ? 4 : 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1;
        tick();
        rst = 0;
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic do_start(input int wc);
        start = 1;
        word_count = wc[AW-2:0];
        tick();
        start = 0;
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        in_valid = 1;
        in_data = w;
        tick();
        in_valid = 0;
        in_data = '0;
        repeat (gap) tick();
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        check("timeout", done || error, 1);
    endtask

    initial begin
        logic [31:0] w, s;
        repeat (2) tick();
        armed = 1;
        check("reset cpu_rst", cpu_rst, 1);
        check("reset busy", busy, 0);
        check("reset checksum", checksum, 0);
        rst = 0;

        do_start(4);
        for (int i = 0; i < 4; i++) send(words[i], 0);
        wait_end(20);
        check("basic done", done, 1);
        check("basic checksum", checksum, 32'h3B5A0002);
        check("basic cpu_rst", cpu_rst, 0);
        check("basic writes", wr_cnt, 4);
        check("basic verify cycles", rd_cnt, 4);
        check("basic mem[3]", mem[3], 32'hffffffff);

        pulse_rst();
        do_start(4);
        for (int i = 0; i < 4; i++) send(words[i], 2);
        wait_end(20);
        check("bp done", done, 1);
        check("bp checksum", checksum, 32'h3B5A0002);
        check("bp writes", wr_cnt, 4);

        pulse_rst();
        do_start(0);
        check("zero done", done, 1);
        check("zero cpu_rst", cpu_rst, 0);
        check("zero writes", wr_cnt, 0);

        pulse_rst();
        do_start(257);
        check("range error", error, 1);
        check("range cpu_rst", cpu_rst, 1);
        check("range writes", wr_cnt, 0);
        s = 0;
        do_start(256);
        for (int i = 0; i < 256; i++) begin
            w = 32'h9e3779b9 * i + 1;
            s += w;
            send(w, 0);
        end
        wait_end(300);
        check("full done", done, 1);
        check("full last addr", last_waddr, 255);
        check("full writes", wr_cnt, 256);
        check("full checksum", checksum, s);

        pulse_rst();
        corrupt = 1;
        do_start(4);
        for (int i = 0; i < 4; i++) send(words[i], 0);
        wait_end(20);
        check("mismatch error", error, 1);
        check("mismatch done", done, 0);
        check("mismatch cpu_rst", cpu_rst, 1);
        corrupt = 0;
        do_start(4);
        for (int i = 0; i < 4; i++) send(words[i], 0);
        wait_end(20);
        check("retry done", done, 1);

        pulse_rst();
        do_start(4);
        send(words[0], 0);
        send(words[1], 0);
        rst = 1;
        tick();
        rst = 0;
        check("abort in_ready", in_ready, 0);
        check("abort cpu_rst", cpu_rst, 1);
        check("abort busy", busy, 0);
        do_start(4);
        for (int i = 0; i < 4; i++) send(words[i], 0);
        wait_end(20);
        check("reload done", done, 1);
        check("reload checksum", checksum, 32'h3B5A0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
- Write-side initiator for the ideal memory's sync-write / async-read port pair.
- Accepts a program/data image as a stream of 32-bit words over a valid/ready handshake and writes it sequentially from word 0.
- Reads the image back through the read port and checks it against a running checksum.
- Holds the CPU core in reset until the image is verified, then releases it. Used on the FPGA top in place of simulation-only memory initialization.

Parameters:
- ADDR_WIDTH, 10, memory address width; must match the attached memory.
- MEM_WIDTH, 2**(ADDR_WIDTH-2), memory depth in 32-bit words.

Ports:
- clk  in  1  single clock, shared with CPU core and memory.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or ERR.
- word_count  in  ADDR_WIDTH-1  number of words to load; sampled on the accepted start.
- in_valid  in  1  image word available.
- in_ready  out  1  loader accepts a word.
- in_data  in  32  image word.
- mem_Waddr  out  ADDR_WIDTH  memory write word index.
- mem_Wren  out  1  memory write enable.
- mem_Wdata  out  32  memory write data.
- mem_Raddr  out  ADDR_WIDTH  memory read word index.
- mem_Rden  out  1  memory read enable.
- mem_Rdata  in  32  memory read data; asynchronous, valid in the same cycle.
- busy  out  1  state is LOAD or VERIFY.
- done  out  1  image loaded and verified (sticky).
- error  out  1  word_count out of range or checksum mismatch.
- checksum  out  32  sum of loaded words, modulo 2^32.
- cpu_rst  out  1  reset to CPU core; high except in DONE.

Behaviour:
- Reset values:
  - state = IDLE; ptr, cnt, load_sum, rd_sum = 0.
  - busy, done, error = 0; checksum = 0; cpu_rst = 1.
  - in_ready, mem_Wren, mem_Rden = 0; all address and data outputs = 0.
- rst takes priority in every state. Reset mid-LOAD or mid-VERIFY aborts on that edge: no further writes, and memory contents already written are left as-is.
- Addresses are word indices, zero-extended to ADDR_WIDTH: ptr occupies bits [ADDR_WIDTH-3:0] and the upper two bits are 0.
- IDLE:
  - start with word_count > MEM_WIDTH -> ERR, no writes.
  - start with word_count == 0 -> DONE; checksum = 0.
  - Otherwise latch cnt = word_count, clear ptr and both sums -> LOAD.
- LOAD:
  - in_ready = 1 for the whole state.
  - Combinational outputs: mem_Wren = in_valid; mem_Waddr = ptr; mem_Wdata = in_data.
  - On each handshake edge the memory writes, ptr increments, and load_sum += in_data (mod 2^32).
  - Handshake with ptr == cnt-1 -> VERIFY with ptr = 0.
  - in_valid low stalls with no write. start is ignored.
- VERIFY:
  - One word per cycle: mem_Rden = 1, mem_Raddr = ptr, in_ready = 0, mem_Wren = 0.
  - rd_sum_next = rd_sum + mem_Rdata.
  - On the cycle with ptr == cnt-1: if rd_sum_next == load_sum -> DONE, else -> ERR.
  - VERIFY lasts exactly cnt cycles.
- DONE: done = 1, cpu_rst = 0, checksum = load_sum. Sticky until rst; start is ignored.
- ERR: error = 1, cpu_rst = 1. start re-enters the IDLE start decode (same range check, same latch) and clears error on that edge.
- busy, done, error, checksum and cpu_rst are registered, i.e. decoded from the state register. in_ready, mem_Wren and mem_Rden are combinational from state and in_valid.
- Latency: the edge accepting the last word enters VERIFY. done and cpu_rst = 0 are first visible cnt cycles later.
- Simultaneous events:
  - start in LOAD/VERIFY/DONE is ignored.
  - in_valid outside LOAD is ignored (in_ready = 0).
- Boundary: word_count == MEM_WIDTH is legal; ptr reaches MEM_WIDTH-1 with no wrap, so address MEM_WIDTH-1 is written last.

Test Plan:
- Basic load (ADDR_WIDTH=10):
  - Stimulus: start, word_count=4, words 0x241a0001, 0x17400002, 0x00000000, 0xffffffff streamed back-to-back.
  - Required: writes to indices 0..3 in 4 consecutive cycles; 4 VERIFY cycles with mem_Rden=1; then done=1, checksum=0x3B5A0002, cpu_rst=0.
- Backpressure:
  - Stimulus: same 4 words with in_valid low for 2 cycles between each word.
  - Required: mem_Wren high only on handshake cycles; same final checksum; done=1.
- Zero count:
  - Stimulus: start with word_count=0.
  - Required: mem_Wren never asserted; done=1 and cpu_rst=0 one cycle after start.
- Range errors:
  - word_count=257 -> error=1 next cycle, no writes, cpu_rst=1.
  - word_count=256 with 256 words -> last write at index 255, then done=1.
- Verify mismatch:
  - Stimulus: bench memory model flips bit 0 of index 2 after LOAD completes.
  - Required: error=1, done=0, cpu_rst=1. A subsequent start plus the 4 words (model no longer corrupts) -> done=1.
- Reset mid-operation:
  - Stimulus: rst pulsed after 2 of 4 words are accepted.
  - Required: next cycle state is IDLE with in_ready=0, cpu_rst=1, busy=0. A new start with 4 words completes normally, with done=1 and checksum=0x3B5A0002.
